// File: rtl/pcm_out_writer_if.sv
// Sample-pair stream from the synthesis filterbank into the PCM output writer.
interface pcm_out_writer_if #(
  parameter int DATA_W = 16
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_ch0;
  logic [DATA_W-1:0] in_ch1;

  modport master (output in_valid, output in_ch0, output in_ch1, input in_ready);
  modport slave  (input in_valid, input in_ch0, input in_ch1, output in_ready);
endinterface

// File: rtl/pcm_out_writer.sv
// Producer side of the stereo PCM circular output buffer: writes L/R pairs, tracks fill against the
// consumer read address, gates playback start and resynchronises after consumer underruns.
module pcm_out_writer #(
  parameter int ADDR_W      = 10,
  parameter int DATA_W      = 16,
  parameter int WR_START    = 448,
  parameter int PRIME_LEVEL = 576
) (
  input  logic              clk,
  input  logic              rst_n,
  pcm_out_writer_if.slave   pcm,
  input  logic              flush,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_d_ch0,
  output logic [DATA_W-1:0] wr_d_ch1,
  output logic [ADDR_W-1:0] fill,
  output logic              buf_full,
  output logic              buf_empty,
  output logic              primed,
  output logic [7:0]        underrun_cnt
);

  localparam logic [ADDR_W-1:0] WR_START_V    = ADDR_W'(WR_START);
  localparam logic [ADDR_W-1:0] PRIME_LEVEL_V = ADDR_W'(PRIME_LEVEL);

  typedef enum logic [1:0] {IDLE, PRIME, RUN} state_t;

  state_t            state;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_prev;
  logic [ADDR_W-1:0] fill_prev;
  logic              ready;
  logic              accept;
  logic              adv;
  logic              underrun;

  // One slot stays unused so that a full buffer never aliases an empty one.
  always_comb begin
    fill      = wr_ptr - rd_addr;
    buf_full  = (fill == '1);
    buf_empty = (fill == '0);
    ready     = !buf_full && !flush;
    accept    = pcm.in_valid && ready;
    adv       = (rd_addr != rd_prev);
    underrun  = (state == RUN) && adv && (fill_prev == '0) && !flush;
  end

  assign pcm.in_ready = ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      wr_ptr       <= WR_START_V;
      rd_prev      <= rd_addr;
      fill_prev    <= '0;
      wr_en        <= 1'b0;
      wr_addr      <= '0;
      wr_d_ch0     <= '0;
      wr_d_ch1     <= '0;
      primed       <= 1'b0;
      underrun_cnt <= 8'd0;
    end else begin
      rd_prev   <= rd_addr;
      fill_prev <= fill;
      wr_en     <= accept;
      // A pair accepted alongside an underrun lands at the resynchronised read position.
      if (accept) begin
        wr_addr  <= underrun ? rd_addr : wr_ptr;
        wr_d_ch0 <= pcm.in_ch0;
        wr_d_ch1 <= pcm.in_ch1;
      end
      if (flush) begin
        wr_ptr <= rd_addr;
        state  <= IDLE;
        primed <= 1'b0;
      end else if (underrun) begin
        wr_ptr <= rd_addr + ADDR_W'(accept);
        state  <= PRIME;
        primed <= 1'b0;
        if (underrun_cnt != 8'hFF) underrun_cnt <= underrun_cnt + 8'd1;
      end else begin
        if (accept) wr_ptr <= wr_ptr + ADDR_W'(1);
        case (state)
          IDLE: if (accept) state <= PRIME;
          PRIME: begin
            if (fill >= PRIME_LEVEL_V) begin
              state  <= RUN;
              primed <= 1'b1;
            end
          end
          RUN:     ;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pcm_out_writer.sv
// Directed bench for pcm_out_writer: streaming, priming, full/backpressure, underrun resync, flush.
module tb_pcm_out_writer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic [9:0]  rd_addr = 10'd448;
  logic        wr_en;
  logic [9:0]  wr_addr;
  logic [15:0] wr_d_ch0;
  logic [15:0] wr_d_ch1;
  logic [9:0]  fill;
  logic        buf_full;
  logic        buf_empty;
  logic        primed;
  logic [7:0]  underrun_cnt;

  int          checks = 0;
  int          passes = 0;
  logic [9:0]  wp;
  int          exp_cnt;

  pcm_out_writer_if #(.DATA_W(16)) pcm ();

  pcm_out_writer #(.ADDR_W(10), .DATA_W(16), .WR_START(448), .PRIME_LEVEL(576)) dut (
    .clk(clk), .rst_n(rst_n), .pcm(pcm), .flush(flush), .rd_addr(rd_addr),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_d_ch0(wr_d_ch0), .wr_d_ch1(wr_d_ch1),
    .fill(fill), .buf_full(buf_full), .buf_empty(buf_empty), .primed(primed),
    .underrun_cnt(underrun_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    pcm.in_valid = 1'b0;
    pcm.in_ch0   = 16'h0;
    pcm.in_ch1   = 16'h0;
    rst_n        = 1'b0;
    rd_addr      = 10'd448;
    tick();
    tick();
    #1;
    checks++; if (fill !== 10'd0) $display("[TB] FAIL reset_fill: got %0d expected 0", fill); else passes++;
    checks++; if (buf_empty !== 1'b1) $display("[TB] FAIL reset_empty: got %b expected 1", buf_empty); else passes++;
    checks++; if (buf_full !== 1'b0) $display("[TB] FAIL reset_full: got %b expected 0", buf_full); else passes++;
    checks++; if (pcm.in_ready !== 1'b1) $display("[TB] FAIL reset_ready: got %b expected 1", pcm.in_ready); else passes++;
    checks++; if ({wr_en, wr_addr, wr_d_ch0, wr_d_ch1, primed, underrun_cnt} !== '0)
      $display("[TB] FAIL reset_outputs: got en=%b addr=%0d d0=%h d1=%h primed=%b cnt=%0d expected all 0",
               wr_en, wr_addr, wr_d_ch0, wr_d_ch1, primed, underrun_cnt);
    else passes++;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_stream();
    for (int i = 0; i < 576; i++) begin
      pcm.in_valid = 1'b1;
      pcm.in_ch0   = 16'(i * 7 + 3);
      pcm.in_ch1   = 16'(32'hA5A5 ^ i);
      tick();
      checks++;
      if (wr_en !== 1'b1 || wr_addr !== 10'(448 + i) || wr_d_ch0 !== 16'(i * 7 + 3) || wr_d_ch1 !== 16'(32'hA5A5 ^ i))
        $display("[TB] FAIL stream_write[%0d]: got en=%b addr=%0d d0=%h d1=%h expected en=1 addr=%0d d0=%h d1=%h",
                 i, wr_en, wr_addr, wr_d_ch0, wr_d_ch1, 10'(448 + i), 16'(i * 7 + 3), 16'(32'hA5A5 ^ i));
      else passes++;
      checks++; if (primed !== 1'b0) $display("[TB] FAIL stream_primed_early[%0d]: got %b expected 0", i, primed); else passes++;
    end
    pcm.in_valid = 1'b0;
    tick();
    checks++; if (primed !== 1'b1) $display("[TB] FAIL stream_primed: got %b expected 1", primed); else passes++;
    checks++; if (wr_en !== 1'b0) $display("[TB] FAIL stream_idle_wr_en: got %b expected 0", wr_en); else passes++;
    #1;
    checks++; if (fill !== 10'd576) $display("[TB] FAIL stream_fill: got %0d expected 576", fill); else passes++;
    wp = 10'd0;
  endtask

  task automatic test_full();
    for (int i = 576; i < 1023; i++) begin
      pcm.in_valid = 1'b1;
      pcm.in_ch0   = 16'(i);
      pcm.in_ch1   = 16'(~i);
      tick();
      checks++;
      if (wr_en !== 1'b1 || wr_addr !== 10'(448 + i) || wr_d_ch0 !== 16'(i))
        $display("[TB] FAIL full_write[%0d]: got en=%b addr=%0d d0=%h expected en=1 addr=%0d d0=%h",
                 i, wr_en, wr_addr, wr_d_ch0, 10'(448 + i), 16'(i));
      else passes++;
    end
    wp = 10'd447;
    pcm.in_ch0 = 16'hBEEF;
    pcm.in_ch1 = 16'hCAFE;
    #1;
    checks++; if (buf_full !== 1'b1) $display("[TB] FAIL full_flag: got %b expected 1", buf_full); else passes++;
    checks++; if (pcm.in_ready !== 1'b0) $display("[TB] FAIL full_ready: got %b expected 0", pcm.in_ready); else passes++;
    tick();
    checks++; if (wr_en !== 1'b0) $display("[TB] FAIL full_no_accept: got %b expected 0", wr_en); else passes++;
    rd_addr = 10'd449;
    #1;
    checks++; if (pcm.in_ready !== 1'b1 || buf_full !== 1'b0)
      $display("[TB] FAIL full_release: got ready=%b full=%b expected ready=1 full=0", pcm.in_ready, buf_full);
    else passes++;
    tick();
    checks++; if (wr_en !== 1'b1 || wr_addr !== 10'd447 || wr_d_ch0 !== 16'hBEEF || wr_d_ch1 !== 16'hCAFE)
      $display("[TB] FAIL full_one_more: got en=%b addr=%0d d0=%h d1=%h expected en=1 addr=447 d0=beef d1=cafe",
               wr_en, wr_addr, wr_d_ch0, wr_d_ch1);
    else passes++;
    #1;
    checks++; if (pcm.in_ready !== 1'b0) $display("[TB] FAIL full_again: got %b expected 0", pcm.in_ready); else passes++;
    tick();
    checks++; if (wr_en !== 1'b0) $display("[TB] FAIL full_stall: got %b expected 0", wr_en); else passes++;
    pcm.in_valid = 1'b0;
    wp = 10'd448;
  endtask

  task automatic test_underrun();
    rd_addr = wp;
    tick();
    tick();
    checks++; if (primed !== 1'b1 || buf_empty !== 1'b1 || underrun_cnt !== 8'd0)
      $display("[TB] FAIL drain_state: got primed=%b empty=%b cnt=%0d expected 1 1 0", primed, buf_empty, underrun_cnt);
    else passes++;
    rd_addr = wp + 10'd1;
    tick();
    checks++; if (underrun_cnt !== 8'd1) $display("[TB] FAIL underrun_cnt: got %0d expected 1", underrun_cnt); else passes++;
    checks++; if (primed !== 1'b0) $display("[TB] FAIL underrun_primed: got %b expected 0", primed); else passes++;
    #1;
    checks++; if (fill !== 10'd0) $display("[TB] FAIL underrun_fill: got %0d expected 0", fill); else passes++;
    wp = wp + 10'd1;
    pcm.in_valid = 1'b1;
    pcm.in_ch0   = 16'h1234;
    pcm.in_ch1   = 16'h5678;
    tick();
    pcm.in_valid = 1'b0;
    checks++; if (wr_en !== 1'b1 || wr_addr !== wp)
      $display("[TB] FAIL underrun_resync_addr: got en=%b addr=%0d expected en=1 addr=%0d", wr_en, wr_addr, wp);
    else passes++;
    wp = wp + 10'd1;
  endtask

  task automatic test_flush();
    flush        = 1'b1;
    pcm.in_valid = 1'b1;
    #1;
    checks++; if (pcm.in_ready !== 1'b0) $display("[TB] FAIL flush_ready: got %b expected 0", pcm.in_ready); else passes++;
    tick();
    flush        = 1'b0;
    pcm.in_valid = 1'b0;
    checks++; if (wr_en !== 1'b0) $display("[TB] FAIL flush_no_accept: got %b expected 0", wr_en); else passes++;
    #1;
    checks++; if (fill !== 10'd0 || buf_empty !== 1'b1)
      $display("[TB] FAIL flush_fill: got fill=%0d empty=%b expected 0 1", fill, buf_empty);
    else passes++;
    wp = rd_addr;
    rd_addr = wp - 10'd600;
    tick();
    tick();
    checks++; if (primed !== 1'b0) $display("[TB] FAIL flush_idle: got primed=%b expected 0", primed); else passes++;
    rd_addr = wp;
    tick();
  endtask

  task automatic test_underrun_saturate();
    exp_cnt = 1;
    pcm.in_valid = 1'b1;
    tick();
    pcm.in_valid = 1'b0;
    wp = wp + 10'd1;
    for (int k = 0; k < 256; k++) begin
      rd_addr = wp - 10'd576;
      tick();
      checks++; if (primed !== 1'b1) $display("[TB] FAIL sat_primed[%0d]: got %b expected 1", k, primed); else passes++;
      rd_addr = wp;
      tick();
      rd_addr = wp + 10'd1;
      tick();
      wp = wp + 10'd1;
      exp_cnt = (exp_cnt < 255) ? exp_cnt + 1 : 255;
      checks++; if (underrun_cnt !== 8'(exp_cnt) || primed !== 1'b0)
        $display("[TB] FAIL sat_cnt[%0d]: got cnt=%0d primed=%b expected cnt=%0d primed=0", k, underrun_cnt, primed, exp_cnt);
      else passes++;
    end
  endtask

  task automatic test_resync_accept();
    rd_addr = wp - 10'd576;
    tick();
    rd_addr = wp;
    tick();
    rd_addr      = wp + 10'd2;
    pcm.in_valid = 1'b1;
    pcm.in_ch0   = 16'h0F0F;
    pcm.in_ch1   = 16'hF0F0;
    tick();
    pcm.in_valid = 1'b0;
    checks++; if (wr_en !== 1'b1 || wr_addr !== wp + 10'd2 || wr_d_ch0 !== 16'h0F0F)
      $display("[TB] FAIL resync_write: got en=%b addr=%0d d0=%h expected en=1 addr=%0d d0=0f0f",
               wr_en, wr_addr, wr_d_ch0, wp + 10'd2);
    else passes++;
    checks++; if (primed !== 1'b0 || underrun_cnt !== 8'd255)
      $display("[TB] FAIL resync_state: got primed=%b cnt=%0d expected 0 255", primed, underrun_cnt);
    else passes++;
    #1;
    checks++; if (fill !== 10'd1) $display("[TB] FAIL resync_fill: got %0d expected 1", fill); else passes++;
  endtask

  task automatic test_reset_mid_write();
    pcm.in_valid = 1'b1;
    tick();
    rst_n = 1'b0;
    tick();
    checks++; if (wr_en !== 1'b0 || wr_addr !== 10'd0 || underrun_cnt !== 8'd0 || primed !== 1'b0)
      $display("[TB] FAIL midreset: got en=%b addr=%0d cnt=%0d primed=%b expected 0 0 0 0",
               wr_en, wr_addr, underrun_cnt, primed);
    else passes++;
    pcm.in_valid = 1'b0;
    rd_addr = 10'd448;
    rst_n = 1'b1;
    #1;
    checks++; if (fill !== 10'd0) $display("[TB] FAIL midreset_fill: got %0d expected 0", fill); else passes++;
    tick();
  endtask

  initial begin
    test_reset();
    test_stream();
    test_full();
    test_underrun();
    test_flush();
    test_underrun_saturate();
    test_resync_accept();
    test_reset_mid_write();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
